// File: rtl/markov_chain_merge.sv
// Merges two packed Markov-chain tables: A is copied, then each B entry is
// summed into a matching A/appended slot or appended after the last used slot.
module markov_chain_merge #(
   parameter int NOTE_BIT_LEN     = 5,
   parameter int DELAY_BIT_LEN    = 3,
   parameter int SEQUENCE_LEN     = 2,
   parameter int SEQ_CNT_BIT_LEN  = 8,
   parameter int MARKOV_CHAIN_LEN = 8,
   localparam int ENTRY_W = SEQUENCE_LEN*(NOTE_BIT_LEN+DELAY_BIT_LEN)+SEQ_CNT_BIT_LEN,
   localparam int SEQ_W   = ENTRY_W-SEQ_CNT_BIT_LEN,
   localparam int FILL_W  = $clog2(2*MARKOV_CHAIN_LEN+1)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [ENTRY_W*MARKOV_CHAIN_LEN-1:0]   chainA,
   input  logic [ENTRY_W*MARKOV_CHAIN_LEN-1:0]   chainB,
   output logic [ENTRY_W*2*MARKOV_CHAIN_LEN-1:0] merged,
   output logic [FILL_W-1:0]                     fill,
   output logic                                  sat,
   output logic                                  done
);

   localparam int LEN   = MARKOV_CHAIN_LEN;
   localparam int SLOTS = 2*MARKOV_CHAIN_LEN;
   localparam int CNT_W = SEQ_CNT_BIT_LEN;
   localparam int IDX_W = $clog2(SLOTS);
   localparam int JW    = (LEN > 1) ? $clog2(LEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [ENTRY_W-1:0]   merged_q [SLOTS];
   logic [ENTRY_W-1:0]   merged_d [SLOTS];
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [FILL_W-1:0]    k_q, k_d;
   logic [JW-1:0]        j_q, j_d;
   logic                 sat_q, sat_d;

   logic [ENTRY_W-1:0]   a_ent [LEN];
   logic [ENTRY_W-1:0]   b_ent [LEN];
   logic [ENTRY_W-1:0]   b_cur, m_cur;
   logic [IDX_W-1:0]     k_slot, f_slot;
   logic [CNT_W:0]       sum;
   logic [CNT_W-1:0]     cnt_new;
   logic                 advance;

   always_comb begin
      for (int unsigned i = 0; i < LEN; i++) begin
         a_ent[i] = chainA[i*ENTRY_W +: ENTRY_W];
         b_ent[i] = chainB[i*ENTRY_W +: ENTRY_W];
      end
   end

   // Slot indices are truncated from fill/k; fill never exceeds SLOTS-1 when used as a write slot.
   always_comb begin
      b_cur   = b_ent[j_q];
      k_slot  = k_q[IDX_W-1:0];
      f_slot  = fill_q[IDX_W-1:0];
      m_cur   = merged_q[k_slot];
      sum     = {1'b0, m_cur[CNT_W-1:0]} + {1'b0, b_cur[CNT_W-1:0]};
      cnt_new = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_comb begin
      state_d  = state_q;
      merged_d = merged_q;
      fill_d   = fill_q;
      k_d      = k_q;
      j_d      = j_q;
      sat_d    = sat_q;
      advance  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               sat_d   = 1'b0;
            end
         end
         S_LOAD: begin
            for (int unsigned i = 0; i < LEN; i++) begin
               merged_d[i]     = a_ent[i];
               merged_d[i+LEN] = '0;
            end
            fill_d  = FILL_W'(LEN);
            j_d     = '0;
            k_d     = '0;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            if (b_cur[CNT_W-1:0] == '0) begin
               advance = 1'b1;
            end else if (k_q < fill_q) begin
               if ((m_cur[CNT_W-1:0] != '0) &&
                   (m_cur[ENTRY_W-1:CNT_W] == b_cur[ENTRY_W-1:CNT_W])) begin
                  merged_d[k_slot] = {m_cur[ENTRY_W-1:CNT_W], cnt_new};
                  if (sum[CNT_W]) sat_d = 1'b1;
                  advance = 1'b1;
               end else begin
                  k_d = k_q + FILL_W'(1);
               end
            end else begin
               merged_d[f_slot] = b_cur;
               fill_d  = fill_q + FILL_W'(1);
               advance = 1'b1;
            end
            if (advance) begin
               j_d = j_q + JW'(1);
               k_d = '0;
               if (j_q == JW'(LEN-1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         fill_q  <= '0;
         k_q     <= '0;
         j_q     <= '0;
         sat_q   <= 1'b0;
         for (int unsigned i = 0; i < SLOTS; i++) merged_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         fill_q   <= fill_d;
         k_q      <= k_d;
         j_q      <= j_d;
         sat_q    <= sat_d;
         merged_q <= merged_d;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < SLOTS; i++) merged[i*ENTRY_W +: ENTRY_W] = merged_q[i];
   end

   assign fill = fill_q;
   assign sat  = sat_q;
   assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_markov_chain_merge.sv
// Directed self-checking bench for markov_chain_merge (default parameters).
module tb_markov_chain_merge;

   localparam int EW  = 24;
   localparam int LEN = 8;
   localparam int FW  = 5;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic [EW*LEN-1:0]     chainA, chainB;
   logic [EW*2*LEN-1:0]   merged;
   logic [FW-1:0]         fill;
   logic                  sat, done;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] a_ent   [LEN];
   logic [EW-1:0] b_ent   [LEN];
   logic [EW-1:0] exp_ent [2*LEN];
   logic [EW*2*LEN-1:0] exp_m;

   markov_chain_merge #(
      .NOTE_BIT_LEN(5), .DELAY_BIT_LEN(3), .SEQUENCE_LEN(2),
      .SEQ_CNT_BIT_LEN(8), .MARKOV_CHAIN_LEN(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .chainA(chainA), .chainB(chainB),
      .merged(merged), .fill(fill), .sat(sat), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [EW-1:0] e(input logic [15:0] s, input logic [7:0] c);
      return {s, c};
   endfunction

   task automatic default_tables();
      for (int i = 0; i < LEN; i++) begin
         a_ent[i] = e(16'h1000 + 16'(i), 8'(i + 1));
         b_ent[i] = '0;
      end
   endtask

   task automatic apply_and_expect_a();
      for (int i = 0; i < LEN; i++) begin
         chainA[i*EW +: EW] = a_ent[i];
         chainB[i*EW +: EW] = b_ent[i];
         exp_ent[i]       = a_ent[i];
         exp_ent[i + LEN] = '0;
      end
   endtask

   task automatic pack_exp();
      for (int i = 0; i < 2*LEN; i++) exp_m[i*EW +: EW] = exp_ent[i];
   endtask

   task automatic run_merge(output int got);
      @(negedge clk);
      start = 1'b1;
      got = -1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin got = n; break; end
      end
   endtask

   task automatic release_start();
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      checks++;
      if (merged !== '0 || fill !== '0 || sat !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: merged=%h fill=%0d sat=%b done=%b, required all 0", merged, fill, sat, done);
      end
   endtask

   task automatic test_empty_b();
      int got;
      default_tables(); apply_and_expect_a(); pack_exp();
      run_merge(got);
      checks++; if (got !== 9) begin errors++; $display("FAIL empty_b_latency: done after edge %0d, required 9", got); end
      checks++; if (merged !== exp_m) begin errors++; $display("FAIL empty_b_merged: got %h required %h", merged, exp_m); end
      checks++; if (fill !== 5'd8 || sat !== 1'b0) begin errors++; $display("FAIL empty_b_fill_sat: fill=%0d sat=%b, required 8/0", fill, sat); end
      release_start();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_b_done_clear: done=%b required 0", done); end
   endtask

   task automatic test_match();
      int got;
      default_tables();
      a_ent[0] = e(16'h03D5, 8'd4);
      b_ent[0] = e(16'h03D5, 8'd6);
      apply_and_expect_a();
      exp_ent[0] = e(16'h03D5, 8'd10);
      pack_exp();
      run_merge(got);
      checks++; if (got !== 9) begin errors++; $display("FAIL match_latency: done after edge %0d, required 9", got); end
      checks++; if (merged !== exp_m || fill !== 5'd8) begin errors++; $display("FAIL match_merged: fill=%0d merged=%h required fill=8 merged=%h", fill, merged, exp_m); end
      release_start();
   endtask

   task automatic test_append();
      int got;
      default_tables();
      b_ent[0] = e(16'h0111, 8'd2);
      apply_and_expect_a();
      exp_ent[8] = e(16'h0111, 8'd2);
      pack_exp();
      run_merge(got);
      checks++; if (got !== 17) begin errors++; $display("FAIL append_latency: done after edge %0d, required 17", got); end
      checks++; if (merged !== exp_m || fill !== 5'd9) begin errors++; $display("FAIL append_merged: fill=%0d merged=%h required fill=9 merged=%h", fill, merged, exp_m); end
      release_start();
   endtask

   task automatic test_saturate();
      int got;
      default_tables();
      a_ent[2] = e(16'h00AB, 8'd200);
      b_ent[5] = e(16'h00AB, 8'd100);
      apply_and_expect_a();
      exp_ent[2] = e(16'h00AB, 8'd255);
      pack_exp();
      run_merge(got);
      checks++; if (got !== 11) begin errors++; $display("FAIL sat_latency: done after edge %0d, required 11", got); end
      checks++; if (merged !== exp_m || sat !== 1'b1) begin errors++; $display("FAIL sat_clamp: sat=%b merged=%h required sat=1 merged=%h", sat, merged, exp_m); end
      release_start();
      checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_sticky_idle: sat=%b required 1", sat); end
      default_tables(); apply_and_expect_a();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_clear_on_start: sat=%b required 0", sat); end
      got = -1;
      for (int n = 1; n < 200; n++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin got = n; break; end
      end
      checks++; if (got !== 9 || sat !== 1'b0) begin errors++; $display("FAIL sat_rerun: done edge %0d sat=%b, required 9/0", got, sat); end
      release_start();
   endtask

   task automatic test_empty_slot();
      int got;
      default_tables();
      a_ent[1] = e(16'h0222, 8'd0);
      b_ent[0] = e(16'h0222, 8'd3);
      apply_and_expect_a();
      exp_ent[8] = e(16'h0222, 8'd3);
      pack_exp();
      run_merge(got);
      checks++; if (got !== 17) begin errors++; $display("FAIL empty_slot_latency: done after edge %0d, required 17", got); end
      checks++; if (merged !== exp_m || fill !== 5'd9) begin errors++; $display("FAIL empty_slot_merged: fill=%0d merged=%h required fill=9 merged=%h", fill, merged, exp_m); end
      release_start();
   endtask

   task automatic setup_multi();
      for (int i = 0; i < LEN; i++) begin a_ent[i] = '0; b_ent[i] = '0; end
      a_ent[0] = e(16'h0100, 8'd1);
      a_ent[1] = e(16'h0200, 8'd2);
      b_ent[0] = e(16'h0200, 8'd5);
      b_ent[1] = e(16'h0300, 8'd7);
      b_ent[2] = e(16'h0300, 8'd2);
      b_ent[7] = e(16'h0100, 8'd1);
      apply_and_expect_a();
      exp_ent[0] = e(16'h0100, 8'd2);
      exp_ent[1] = e(16'h0200, 8'd7);
      exp_ent[8] = e(16'h0300, 8'd9);
      pack_exp();
   endtask

   task automatic test_multi();
      int got;
      setup_multi();
      run_merge(got);
      checks++; if (got !== 26) begin errors++; $display("FAIL multi_latency: done after edge %0d, required 26", got); end
      checks++; if (merged !== exp_m || fill !== 5'd9 || sat !== 1'b0) begin errors++; $display("FAIL multi_merged: fill=%0d sat=%b merged=%h required fill=9 sat=0 merged=%h", fill, sat, merged, exp_m); end
      release_start();
   endtask

   task automatic test_reset_mid();
      int got;
      default_tables();
      b_ent[0] = e(16'h0111, 8'd2);
      apply_and_expect_a();
      exp_ent[8] = e(16'h0111, 8'd2);
      pack_exp();
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n <= 4; n++) begin @(posedge clk); #1; end
      checks++; if (fill !== 5'd8) begin errors++; $display("FAIL reset_mid_preload: fill=%0d required 8", fill); end
      reset = 1'b0;
      start = 1'b0;
      #1;
      checks++; if (merged !== '0 || fill !== '0 || sat !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid_clear: merged=%h fill=%0d sat=%b done=%b, required all 0", merged, fill, sat, done); end
      @(negedge clk);
      reset = 1'b1;
      run_merge(got);
      checks++; if (got !== 17 || merged !== exp_m || fill !== 5'd9) begin errors++; $display("FAIL reset_mid_rerun: edge %0d fill=%0d merged=%h required 17/9/%h", got, fill, merged, exp_m); end
      release_start();
   endtask

   task automatic test_hold_start();
      int got;
      setup_multi();
      run_merge(got);
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (done !== 1'b1 || merged !== exp_m || fill !== 5'd9) begin errors++; $display("FAIL hold_stable: done=%b fill=%0d merged=%h required 1/9/%h", done, fill, merged, exp_m); end
      release_start();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_drop: done=%b required 0", done); end
      run_merge(got);
      checks++; if (got !== 26 || merged !== exp_m) begin errors++; $display("FAIL hold_restart: edge %0d merged=%h required 26/%h", got, merged, exp_m); end
      release_start();
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      chainA = '0;
      chainB = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      reset = 1'b1;
      test_empty_b();
      test_match();
      test_append();
      test_saturate();
      test_empty_slot();
      test_multi();
      test_reset_mid();
      test_hold_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
